// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the memory stage: opcodes, M-stage FSM encoding
// and the default bubble instruction word.
package mips_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mstate_e;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU) ||
               (op == OP_LH) || (op == OP_LHU);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SW) || (op == OP_SB) || (op == OP_SH);
    endfunction

endpackage

// File: rtl/mem_access_stage_load_ext.sv
// Load data extraction: selects the byte/half lane addressed by the low
// address bits and sign- or zero-extends it to 32 bits.
module load_ext
    import mips_pkg::*;
(
    input  logic [5:0]  op_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        case (addr_i)
            2'd0:    byte_v = rdata_i[7:0];
            2'd1:    byte_v = rdata_i[15:8];
            2'd2:    byte_v = rdata_i[23:16];
            default: byte_v = rdata_i[31:24];
        endcase
        half_v = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        case (op_i)
            OP_LB:   result_o = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  result_o = {24'h0, byte_v};
            OP_LH:   result_o = {{16{half_v[15]}}, half_v};
            OP_LHU:  result_o = {16'h0, half_v};
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS M stage with M/W register: drives a req/ack data memory and stalls the
// pipe while busy. Optional misalignment trap via MEM_ALIGN_CHECK_EN.
module mem_access_stage
    import mips_pkg::*;
#(
    parameter int          DM_WAIT_MAX = 64,
    parameter logic [31:0] NOP_INSTR   = mips_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_m,
    input  logic [31:0] aluout_m,
    input  logic [31:0] wdata_m,
    input  logic [31:0] pc8_m,
    output logic        dm_req,
    output logic        dm_we,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        stall_m,
    output logic        bus_err,
    output logic [31:0] instr_w,
    output logic [31:0] aluout_w,
    output logic [31:0] dmout_w,
    output logic [31:0] pc8_w
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic        align_exc
`endif
);

    localparam logic [7:0] WAIT_LAST = 8'(DM_WAIT_MAX - 1);

    mstate_e     state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wd_q, wd_d;
    logic        berr_q, berr_d;
    logic [31:0] ld_q, ld_d;
    logic [5:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] instr_w_q, instr_w_d;
    logic [31:0] aluout_w_q, aluout_w_d;
    logic [31:0] dmout_w_q, dmout_w_d;
    logic [31:0] pc8_w_q, pc8_w_d;
    logic        aexc_q, aexc_d;

    logic [5:0]  op_m;
    logic        mem_m;
    logic        misalign_m;
    logic        access_m;
    logic        trap_m;
    logic        timeout;
    logic        fmt_we;
    logic [3:0]  fmt_be;
    logic [31:0] fmt_wd;
    logic [31:0] ext_data;

    assign op_m  = instr_m[31:26];
    assign mem_m = is_load(op_m) || is_store(op_m);

    always_comb begin
        misalign_m = 1'b0;
        if ((op_m == OP_LW) || (op_m == OP_SW))
            misalign_m = (aluout_m[1:0] != 2'b00);
        else if ((op_m == OP_LH) || (op_m == OP_LHU) || (op_m == OP_SH))
            misalign_m = aluout_m[0];
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign access_m = mem_m && !misalign_m;
    assign trap_m   = mem_m && misalign_m;
`else
    assign access_m = mem_m;
    assign trap_m   = 1'b0;
`endif

    // Byte enables for loads as well, so the memory sees which lanes are used.
    always_comb begin
        fmt_we = 1'b0;
        fmt_be = 4'b0000;
        fmt_wd = 32'h0;
        case (op_m)
            OP_SW: begin
                fmt_we = 1'b1;
                fmt_be = 4'b1111;
                fmt_wd = wdata_m;
            end
            OP_SH: begin
                fmt_we = 1'b1;
                fmt_be = aluout_m[1] ? 4'b1100 : 4'b0011;
                fmt_wd = {2{wdata_m[15:0]}};
            end
            OP_SB: begin
                fmt_we = 1'b1;
                fmt_be = 4'b0001 << aluout_m[1:0];
                fmt_wd = {4{wdata_m[7:0]}};
            end
            OP_LW:          fmt_be = 4'b1111;
            OP_LH, OP_LHU:  fmt_be = aluout_m[1] ? 4'b1100 : 4'b0011;
            OP_LB, OP_LBU:  fmt_be = 4'b0001 << aluout_m[1:0];
            default: ;
        endcase
    end

    load_ext u_load_ext (
        .op_i     (op_q),
        .addr_i   (off_q),
        .rdata_i  (dm_rdata),
        .result_o (ext_data)
    );

    assign timeout = (state_q == ST_BUSY) && !dm_ack && (cnt_q == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (access_m) state_d = ST_BUSY;
            ST_BUSY: if (dm_ack || timeout) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // W defaults to a bubble; only a completing or non-memory instruction overrides it.
    always_comb begin
        stall_m    = 1'b0;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        be_d       = be_q;
        addr_d     = addr_q;
        wd_d       = wd_q;
        berr_d     = berr_q;
        ld_d       = ld_q;
        op_d       = op_q;
        off_d      = off_q;
        instr_w_d  = NOP_INSTR;
        aluout_w_d = 32'h0;
        dmout_w_d  = 32'h0;
        pc8_w_d    = 32'h0;
        aexc_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access_m) begin
                    stall_m = 1'b1;
                    req_d   = 1'b1;
                    we_d    = fmt_we;
                    be_d    = fmt_be;
                    addr_d  = {aluout_m[31:2], 2'b00};
                    wd_d    = fmt_wd;
                    op_d    = op_m;
                    off_d   = aluout_m[1:0];
                    cnt_d   = 8'd0;
                end else if (trap_m) begin
                    aexc_d = 1'b1;
                end else begin
                    instr_w_d  = instr_m;
                    aluout_w_d = aluout_m;
                    pc8_w_d    = pc8_m;
                end
            end
            ST_BUSY: begin
                stall_m = 1'b1;
                cnt_d   = cnt_q + 8'd1;
                if (dm_ack) begin
                    req_d = 1'b0;
                    ld_d  = is_load(op_q) ? ext_data : 32'h0;
                end else if (timeout) begin
                    req_d  = 1'b0;
                    berr_d = 1'b1;
                    ld_d   = 32'h0;
                end
            end
            ST_DONE: begin
                cnt_d      = 8'd0;
                instr_w_d  = instr_m;
                aluout_w_d = aluout_m;
                dmout_w_d  = ld_q;
                pc8_w_d    = pc8_m;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= 8'd0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= 4'b0000;
            addr_q     <= 32'h0;
            wd_q       <= 32'h0;
            berr_q     <= 1'b0;
            ld_q       <= 32'h0;
            op_q       <= 6'h0;
            off_q      <= 2'b00;
            instr_w_q  <= NOP_INSTR;
            aluout_w_q <= 32'h0;
            dmout_w_q  <= 32'h0;
            pc8_w_q    <= 32'h0;
            aexc_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            wd_q       <= wd_d;
            berr_q     <= berr_d;
            ld_q       <= ld_d;
            op_q       <= op_d;
            off_q      <= off_d;
            instr_w_q  <= instr_w_d;
            aluout_w_q <= aluout_w_d;
            dmout_w_q  <= dmout_w_d;
            pc8_w_q    <= pc8_w_d;
            aexc_q     <= aexc_d;
        end
    end

    assign dm_req   = req_q;
    assign dm_we    = we_q;
    assign dm_be    = be_q;
    assign dm_addr  = addr_q;
    assign dm_wdata = wd_q;
    assign bus_err  = berr_q;
    assign instr_w  = instr_w_q;
    assign aluout_w = aluout_w_q;
    assign dmout_w  = dmout_w_q;
    assign pc8_w    = pc8_w_q;

`ifdef MEM_ALIGN_CHECK_EN
    assign align_exc = aexc_q;
`else
    logic unused_aexc;
    assign unused_aexc = aexc_q;
`endif

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MIPS pipeline memory (M) stage plus the M/W pipeline register.
- Drives a variable-latency data memory over a req/ack handshake and stalls the pipeline while an access is outstanding.
- Formats store data and byte enables; sign- or zero-extends load data.
- Registers instr_w/aluout_w/dmout_w/pc8_w for the writeback stage.

Parameters:
- DM_WAIT_MAX, 64: maximum cycles in BUSY before a bus error is flagged (range 1..255).
- NOP_INSTR, 32'h0000_0000: instruction word inserted into W as a bubble.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- instr_m  in  32  M-stage instruction; upstream holds it while stall_m=1.
- aluout_m  in  32  ALU result; byte address for loads/stores.
- wdata_m  in  32  forwarded rt value for stores.
- pc8_m  in  32  PC+8 of the M instruction.
- dm_req  out  1  memory request, registered.
- dm_we  out  1  1 = store.
- dm_be  out  4  byte enables (bit i = byte i, little-endian).
- dm_addr  out  32  word address, {aluout_m[31:2],2'b00}.
- dm_wdata  out  32  lane-replicated store data.
- dm_ack  in  1  one-cycle completion pulse.
- dm_rdata  in  32  read word, valid with dm_ack.
- stall_m  out  1  hold IF..M, bubble into W.
- bus_err  out  1  sticky timeout flag.
- instr_w, aluout_w, dmout_w, pc8_w  out  32 each  registered W-stage values.

Behaviour:
- Reset: all outputs 0 except instr_w=NOP_INSTR. FSM=IDLE, wait counter=0, bus_err=0.
- Decode on instr_m[31:26]:
  - Loads: lw 0x23, lb 0x20, lbu 0x24, lh 0x21, lhu 0x25.
  - Stores: sw 0x2B, sb 0x28, sh 0x29.
  - Anything else is non-memory.
- FSM IDLE:
  - Non-memory instr_m: stall_m=0; W registers load the M values at the edge, dmout_w=0. Latency 1 cycle.
  - Memory instr_m: stall_m=1 combinationally. At the edge, register dm_req=1, dm_we, dm_be, dm_addr, dm_wdata. Go to BUSY. W loads a bubble (NOP_INSTR, others 0).
- FSM BUSY:
  - dm_* held stable, stall_m=1, W gets bubbles, counter increments each cycle.
  - dm_ack=1: latch the extended load result (0 for stores), drop dm_req at the edge, go to DONE.
  - Counter reaches DM_WAIT_MAX with no ack: set bus_err, drop dm_req, go to DONE with load result 0.
- FSM DONE:
  - stall_m=0; W loads instr_m/aluout_m/pc8_m plus the latched data. Counter clears. Go to IDLE.
  - A memory access therefore costs 3 cycles minimum (IDLE, BUSY with immediate ack, DONE).
- Store formatting:
  - sw: be=4'b1111, wdata=wdata_m.
  - sh: be = addr[1] ? 4'b1100 : 4'b0011, wdata={2{wdata_m[15:0]}}.
  - sb: be = 4'b0001<<addr[1:0], wdata={4{wdata_m[7:0]}}.
- Load extraction:
  - Byte lane selected by addr[1:0]; half selected by addr[1].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
- Boundary rules:
  - dm_ack in IDLE or DONE is ignored.
  - dm_ack in the same cycle as the timeout: ack wins, bus_err not set.
  - bus_err clears only on reset.
  - Reset mid-BUSY: dm_req=0 after that edge, no W write, FSM=IDLE.
  - Back-to-back memory instructions: the second enters IDLE after DONE; no overlap.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- When defined:
  - Adds output align_exc (1 bit, registered).
  - A lw/sw with addr[1:0]≠0, or a lh/lhu/sh with addr[0]=1, issues no request.
  - The instruction goes to W as NOP_INSTR with align_exc=1 for that one cycle.
  - No stall, FSM stays IDLE.
- When undefined: no port. The address is silently truncated as described above.

Decomposition:
- Shared package mips_pkg: opcode constants (OP_LW, OP_LB, ...), FSM state encoding (IDLE/BUSY/DONE), NOP_INSTR value.
- Sub-module load_ext (combinational): op, addr[1:0], rdata → 32-bit extended result; reused by the verification reference model.

Test Plan:
- Non-memory flow: addu with aluout_m=0x0000_0010 → instr_w and aluout_w=0x10 next cycle, stall_m never asserted.
- sb store: addr=0x1003, wdata_m=0x1234_56AB, dm_ack after 2 BUSY cycles → dm_be=4'b1000, dm_wdata=0xABABABAB, dm_addr=0x1000; stall_m high for 3 cycles; then instr_w=sb.
- Load extension: dm_rdata=0x80FF_7F01.
  - lb @+3 → dmout_w=0xFFFF_FF80.
  - lbu @+1 → 0x0000_007F.
  - lh @+2 → 0xFFFF_80FF.
  - lhu @+0 → 0x0000_7F01.
- Timeout: DM_WAIT_MAX=4, never ack → dm_req drops after 4 BUSY cycles, bus_err=1 sticky, dmout_w=0.
- Reset during BUSY: assert reset 1 cycle → dm_req=0, instr_w=NOP, FSM IDLE; a subsequent lw with immediate ack completes normally.
- With MEM_ALIGN_CHECK_EN: lw @0x1002 → no dm_req, align_exc=1 for 1 cycle, instr_w=NOP.
